// File: rtl/float_add_seq.sv
// -----------------------------------------------------------------------------
// float_add_seq
//
// Multi-cycle single-precision floating-point adder. It sits downstream of the
// combinational multiplier in the atanh CORDIC datapath and combines products.
// The number format is a simplified IEEE-754 subset:
//   - no denormals, NaN or infinity inputs
//   - an exponent field of 0 means zero
//   - rounding is by truncation
// Normalisation shifts one bit per cycle, so the latency depends on the data.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   a, b       operands, sampled on the edge where in_valid && in_ready
//   in_valid   operands valid
//   in_ready   block can accept operands (high only in IDLE)
//   result     registered sum, valid while out_valid is high
//   out_valid  result available (high only in DONE)
//   out_ready  consumer accepts result
//
// Flow: IDLE -> ALIGN -> ADD -> (NORM)* -> DONE -> IDLE.
// At most one operation is in flight at a time.
// -----------------------------------------------------------------------------
module float_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;

  // Latched operands
  logic [31:0] op_a;
  logic [31:0] op_b;

  // Aligned operands: X has the larger magnitude
  logic        sign_x;
  logic        sign_y;
  logic [23:0] mant_x;
  logic [23:0] mant_y;

  // Working exponent. It is one bit wider than the field so that the
  // increment on carry cannot wrap.
  logic [8:0]  exp_w;

  // Working sum (used in NORM) and result sign
  logic [24:0] sum;
  logic        res_sign;

  // ---------------------------------------------------------------------------
  // Operand decode and alignment (used in ALIGN)
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        a_is_x;

  assign exp_a  = op_a[30:23];
  assign exp_b  = op_b[30:23];
  // The hidden bit is present only for non-zero exponents.
  assign mant_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
  assign mant_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};

  // Magnitude compare: exponent first, then mantissa. A full tie keeps a as X.
  assign a_is_x = (exp_a > exp_b) ||
                  ((exp_a == exp_b) && (mant_a >= mant_b));

  logic        al_sign_x;
  logic        al_sign_y;
  logic [7:0]  al_exp_x;
  logic [7:0]  al_exp_y;
  logic [23:0] al_mant_x;
  logic [23:0] al_mant_y;
  logic [7:0]  al_diff;
  logic [23:0] al_mant_y_sh;

  // NOTE: every signal assigned in this always_comb gets a default value
  // first. A path that left one unassigned would infer a latch.
  always_comb begin
    al_sign_x = op_a[31];
    al_sign_y = op_b[31];
    al_exp_x  = exp_a;
    al_exp_y  = exp_b;
    al_mant_x = mant_a;
    al_mant_y = mant_b;
    if (!a_is_x) begin
      al_sign_x = op_b[31];
      al_sign_y = op_a[31];
      al_exp_x  = exp_b;
      al_exp_y  = exp_a;
      al_mant_x = mant_b;
      al_mant_y = mant_a;
    end
  end

  // The difference is never negative because X was chosen as the larger
  // exponent. A shift of 25 or more leaves nothing of a 24-bit mantissa.
  assign al_diff      = al_exp_x - al_exp_y;
  assign al_mant_y_sh = (al_diff >= 8'd25) ? 24'd0 : (al_mant_y >> al_diff);

  // ---------------------------------------------------------------------------
  // Add/subtract (used in ADD)
  // ---------------------------------------------------------------------------
  logic [24:0] add_sum;
  logic [8:0]  add_exp_inc;

  // X >= Y in magnitude, so subtraction never goes negative.
  assign add_sum     = (sign_x == sign_y) ? ({1'b0, mant_x} + {1'b0, mant_y})
                                          : ({1'b0, mant_x} - {1'b0, mant_y});
  assign add_exp_inc = exp_w + 9'd1;

  // ---------------------------------------------------------------------------
  // Normalise step (used in NORM): one left shift per cycle
  // ---------------------------------------------------------------------------
  logic [24:0] norm_sum;
  logic [8:0]  norm_exp;

  assign norm_sum = {sum[23:0], 1'b0};
  assign norm_exp = exp_w - 9'd1;

  // ---------------------------------------------------------------------------
  // Handshake outputs come straight from the state register, so there is no
  // combinational path from the inputs.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Sequential control and datapath
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only. All registers
  // then see values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      sign_x   <= 1'b0;
      sign_y   <= 1'b0;
      mant_x   <= 24'd0;
      mant_y   <= 24'd0;
      exp_w    <= 9'd0;
      sum      <= 25'd0;
      res_sign <= 1'b0;
      result   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            state <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          sign_x <= al_sign_x;
          sign_y <= al_sign_y;
          mant_x <= al_mant_x;
          mant_y <= al_mant_y_sh;
          exp_w  <= {1'b0, al_exp_x};
          state  <= S_ADD;
        end

        S_ADD: begin
          res_sign <= sign_x;
          if (add_sum == 25'd0) begin
            // Exact cancellation always gives +0.
            result <= 32'h0000_0000;
            state  <= S_DONE;
          end else if (add_sum[24]) begin
            // Carry out: shift right once. The dropped LSB is truncated.
            exp_w <= add_exp_inc;
            if (add_exp_inc == 9'd255)
              result <= {sign_x, 8'hFF, 23'd0};
            else
              result <= {sign_x, add_exp_inc[7:0], add_sum[23:1]};
            state <= S_DONE;
          end else if (add_sum[23]) begin
            result <= {sign_x, exp_w[7:0], add_sum[22:0]};
            state  <= S_DONE;
          end else begin
            sum   <= add_sum;
            state <= S_NORM;
          end
        end

        S_NORM: begin
          if (norm_exp == 9'd0) begin
            // Exponent underflow: no denormals, so flush to +0.
            result <= 32'h0000_0000;
            state  <= S_DONE;
          end else if (norm_sum[23]) begin
            result <= {res_sign, norm_exp[7:0], norm_sum[22:0]};
            state  <= S_DONE;
          end else begin
            sum   <= norm_sum;
            exp_w <= norm_exp;
          end
        end

        S_DONE: begin
          // result holds steady until the consumer takes it.
          if (out_ready)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_seq.sv
// -----------------------------------------------------------------------------
// tb_float_add_seq
//
// Directed testbench for float_add_seq. The expected results and latencies are
// worked out by hand from the number format. Latency counts the clock cycles
// after the accept edge, up to and including the first cycle with out_valid
// high. Outputs are sampled on the falling edge. Inputs change just after a
// rising edge, or on a falling edge.
// -----------------------------------------------------------------------------
module tb_float_add_seq;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  float_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Issues one operation, waits for the result with a bounded wait, checks the
  // result, the latency and that in_ready stays low, then consumes the result.
  // The caller must be at a falling edge with in_ready high. The task returns
  // at a falling edge with the block idle again.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input string tag);
    int   lat;
    logic saw_ready;
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    lat       = 0;
    saw_ready = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (in_ready) saw_ready = 1'b1;
      if (out_valid) break;
    end
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " in_ready low while busy"}, {31'd0, saw_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " in_ready after transfer"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int   wait_n;
    logic emitted;

    rst       = 1'b1;
    a         = 32'd0;
    b         = 32'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry path
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, "1+1");
    // One normalise shift, in both operand orders
    run_op(32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 4, "1.5-1");
    run_op(32'hBF80_0000, 32'h3FC0_0000, 32'h3F00_0000, 4, "-1+1.5");
    // Cancellation and zero operand
    run_op(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3, "1-1");
    run_op(32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDB, 3, "0+pi");
    // Alignment limits
    run_op(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 3, "d24");
    run_op(32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 3, "d25");
    run_op(32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, 26, "norm23");
    // Negative result: the sign comes from the larger operand
    run_op(32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000, 4, "-2+1");

    // Backpressure: hold out_ready low while a new in_valid is offered
    a        = 32'h3F80_0000;
    b        = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_n   = 0;
    while (!out_valid && wait_n < 60) begin
      @(negedge clk);
      wait_n++;
    end
    check("bp out_valid", {31'd0, out_valid}, 32'd1);
    a        = 32'h4049_0FDB;
    b        = 32'h4049_0FDB;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp result stable", result, 32'h4000_0000);
      check("bp out_valid held", {31'd0, out_valid}, 32'd1);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp in_ready after transfer", {31'd0, in_ready}, 32'd1);
    check("bp out_valid after transfer", {31'd0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp pulse not accepted", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a long normalisation
    a        = 32'h3F80_0001;
    b        = 32'hBF80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-reset busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid reset result", result, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    out_ready = 1'b1;
    emitted = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) emitted = 1'b1;
    end
    out_ready = 1'b0;
    check("no result after reset", {31'd0, emitted}, 32'd0);
    check("idle after reset", {31'd0, in_ready}, 32'd1);
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3, "post-reset 1+1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus itself deadlocks.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
